axi_pim_master: RTL

AXI4 master that drives the PIM array slave over a full AXI4 port. It accepts one burst command at a time from a local controller, for example a weight loader or a result reader. Write commands stream data from a local valid/ready source into INCR write bursts. Read commands return INCR read-burst data to a local valid/ready sink. Done and response are reported per command.

---
 rtl/axi_pim_pkg.sv | 24 ++
 rtl/axi_pim_master_if.sv | 78 +++++++
 rtl/axi_pim_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pim_pkg.sv
// Shared AXI constants, FSM state type and a response helper for the PIM master.
package axi_pim_pkg;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R
    } state_t;

    // Worst-of two AXI responses (numerically larger is worse).
    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_pim_master_if.sv
// Full AXI4 bus between the PIM master and the PIM array slave.
// Handshake rule on every channel: a beat transfers on a rising clk edge where
// both valid and ready are high; the sender holds payload stable while valid
// is high and ready is low.
interface axi_pim_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int ID_WIDTH   = 8
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arlock;
    logic [3:0]            arcache;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_pim_master.sv
// Single-command AXI4 burst master: write bursts stream from a local source,
// read bursts stream to a local sink, done/resp report each command.
module axi_pim_master
    import axi_pim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8,
    parameter logic [ID_WIDTH-1:0] M_ID = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  done,
    output logic [1:0]            resp,
    output logic                  busy,
    output state_t                dbg_state,
    axi_pim_master_if.master      m_axi
);

    localparam logic [2:0] AXI_SIZE = 3'($clog2(STRB_WIDTH));

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            beat_cnt;
    logic                  done_q;
    logic [1:0]            resp_q;
    logic [1:0]            rd_resp_acc;
    logic                  rd_err;
    logic                  cmd_fire;
    logic                  beat_last;
    logic                  w_fire;
    logic                  b_fire;
    logic                  r_fire;
    logic                  rlast_bad;
    logic                  unused_ids;

    assign cmd_ready = (state == ST_IDLE) && !rst;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_last = (beat_cnt == len_q);
    assign w_fire    = (state == ST_W) && wr_valid && m_axi.wready;
    assign b_fire    = (state == ST_B) && m_axi.bvalid;
    assign r_fire    = (state == ST_R) && m_axi.rvalid && rd_ready;
    assign rlast_bad = (m_axi.rlast != beat_last);

    // Constant address-channel attributes; address and len come from the latches.
    assign m_axi.awid    = M_ID;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awlock  = 1'b0;
    assign m_axi.awcache = AXI_CACHE_DEFAULT;
    assign m_axi.awprot  = AXI_PROT_DEFAULT;
    assign m_axi.arid    = M_ID;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = AXI_SIZE;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arlock  = 1'b0;
    assign m_axi.arcache = AXI_CACHE_DEFAULT;
    assign m_axi.arprot  = AXI_PROT_DEFAULT;

    // Data buses pass straight through; only the valid/ready pairs are gated by state.
    assign m_axi.wdata = wr_data;
    assign m_axi.wstrb = wr_strb;
    assign rd_data     = m_axi.rdata;

    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;
    assign done      = done_q;
    assign resp      = resp_q;

    // Response IDs are not used: only one command is ever outstanding.
    assign unused_ids = ^{m_axi.bid, m_axi.rid};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state and channel handshake outputs.
    always_comb begin
        state_next    = state;
        m_axi.awvalid = 1'b0;
        m_axi.wvalid  = 1'b0;
        m_axi.wlast   = 1'b0;
        m_axi.bready  = 1'b0;
        m_axi.arvalid = 1'b0;
        m_axi.rready  = 1'b0;
        wr_ready      = 1'b0;
        rd_valid      = 1'b0;
        rd_last       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) state_next = cmd_write ? ST_AW : ST_AR;
            end
            ST_AW: begin
                m_axi.awvalid = 1'b1;
                if (m_axi.awready) state_next = ST_W;
            end
            ST_W: begin
                m_axi.wvalid = wr_valid;
                m_axi.wlast  = beat_last;
                wr_ready     = m_axi.wready;
                if (w_fire && beat_last) state_next = ST_B;
            end
            ST_B: begin
                m_axi.bready = 1'b1;
                if (m_axi.bvalid) state_next = ST_IDLE;
            end
            ST_AR: begin
                m_axi.arvalid = 1'b1;
                if (m_axi.arready) state_next = ST_R;
            end
            ST_R: begin
                rd_valid     = m_axi.rvalid;
                rd_last      = beat_last;
                m_axi.rready = rd_ready;
                if (r_fire && beat_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Command latches, beat counter and completion reporting.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt    <= '0;
            done_q      <= 1'b0;
            resp_q      <= AXI_RESP_OKAY;
            rd_resp_acc <= AXI_RESP_OKAY;
            rd_err      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cmd_fire) begin
                addr_q      <= cmd_addr;
                len_q       <= cmd_len;
                beat_cnt    <= '0;
                rd_resp_acc <= AXI_RESP_OKAY;
                rd_err      <= 1'b0;
            end
            if (w_fire) beat_cnt <= beat_cnt + 8'd1;
            if (b_fire) begin
                done_q <= 1'b1;
                resp_q <= m_axi.bresp;
            end
            if (r_fire) begin
                beat_cnt    <= beat_cnt + 8'd1;
                rd_resp_acc <= resp_max(rd_resp_acc, m_axi.rresp);
                rd_err      <= rd_err || rlast_bad;
                if (beat_last) begin
                    done_q <= 1'b1;
                    // A misplaced rlast anywhere in the burst overrides any response code.
                    resp_q <= (rd_err || rlast_bad) ? AXI_RESP_SLVERR
                                                    : resp_max(rd_resp_acc, m_axi.rresp);
                end
            end
        end
    end

endmodule
